// File: rtl/cam_alloc_ctrl_if.sv
// Request/status channel (requester -> controller) and cam write/search channel (controller -> cam).
// Active-low strobes keep the cam's native polarity; masks are carried but always zero.
interface cam_alloc_ctrl_if #(
  parameter int KEY   = 16,
  parameter int DEPTH = 32
);
  localparam int ADDR = $clog2(DEPTH);

  logic            ins_req_;
  logic [KEY-1:0]  ins_key;
  logic            ins_ready;
  logic            ins_done;
  logic            ins_hit;
  logic            ins_full;
  logic [ADDR-1:0] ins_addr;
  logic            del_req_;
  logic [ADDR-1:0] del_addr;
  logic            del_done;
  logic [ADDR:0]   count;
  logic            err;

  modport master (
    output ins_req_, ins_key, del_req_, del_addr,
    input  ins_ready, ins_done, ins_hit, ins_full, ins_addr, del_done, count, err
  );
  modport slave (
    input  ins_req_, ins_key, del_req_, del_addr,
    output ins_ready, ins_done, ins_hit, ins_full, ins_addr, del_done, count, err
  );
endinterface

interface cam_port_if #(
  parameter int KEY   = 16,
  parameter int DEPTH = 32
);
  localparam int ADDR = $clog2(DEPTH);

  logic            cam_we_;
  logic [KEY:0]    cam_wm;
  logic [KEY:0]    cam_wd;
  logic [ADDR-1:0] cam_waddr;
  logic            cam_re_;
  logic [KEY:0]    cam_rm;
  logic [KEY:0]    cam_rd;
  logic            cam_match;
  logic            cam_multi;
  logic [ADDR-1:0] cam_raddr;

  modport master (
    output cam_we_, cam_wm, cam_wd, cam_waddr, cam_re_, cam_rm, cam_rd,
    input  cam_match, cam_multi, cam_raddr
  );
  modport slave (
    input  cam_we_, cam_wm, cam_wd, cam_waddr, cam_re_, cam_rm, cam_rd,
    output cam_match, cam_multi, cam_raddr
  );
endinterface

// File: rtl/cam_alloc_ctrl.sv
// CAM insert/delete controller: duplicate search, lowest-free allocation, tag-clear delete.
// Insert done 3 cycles after accept (2 on hit/full), delete done 2; ins_ready low while busy or deleting.
module cam_alloc_ctrl #(
  parameter int KEY   = 16,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  cam_alloc_ctrl_if.slave  req,
  cam_port_if.master       cam
);
  localparam int ADDR = $clog2(DEPTH);
  localparam logic [ADDR:0] FULL_CNT = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0] ONE      = (ADDR+1)'(1);

  typedef enum logic [2:0] {IDLE, SEARCH, WRITE, DEL, DONE} state_t;

  state_t          state_q, state_d;
  logic [KEY-1:0]  key_q, key_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [ADDR-1:0] del_addr_q, del_addr_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [ADDR:0]   count_q, count_d;
  logic            err_q, err_d;
  logic            hit_q, hit_d;
  logic            full_q, full_d;
  logic            del_done_q;
  logic [ADDR-1:0] free_addr;

  logic            ins_ready, ins_done;
  logic            we_n, re_n;
  logic [KEY:0]    wd, rd;
  logic [ADDR-1:0] waddr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      key_q      <= '0;
      addr_q     <= '0;
      del_addr_q <= '0;
      valid_q    <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      hit_q      <= 1'b0;
      full_q     <= 1'b0;
      del_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      addr_q     <= addr_d;
      del_addr_q <= del_addr_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      err_q      <= err_d;
      hit_q      <= hit_d;
      full_q     <= full_d;
      del_done_q <= (state_q == DEL);
    end
  end

  // Descending scan so the lowest clear bit is the last one to win.
  always_comb begin
    free_addr = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_addr = ADDR'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    addr_d     = addr_q;
    del_addr_d = del_addr_q;
    valid_d    = valid_q;
    count_d    = count_q;
    err_d      = err_q;
    hit_d      = hit_q;
    full_d     = full_q;
    ins_ready  = 1'b0;
    ins_done   = 1'b0;
    we_n       = 1'b1;
    re_n       = 1'b1;
    wd         = '0;
    rd         = '0;
    waddr      = '0;
    case (state_q)
      IDLE: begin
        if (!req.del_req_) begin
          del_addr_d = req.del_addr;
          state_d    = DEL;
        end else begin
          ins_ready = 1'b1;
          if (!req.ins_req_) begin
            key_d   = req.ins_key;
            hit_d   = 1'b0;
            full_d  = 1'b0;
            state_d = SEARCH;
          end
        end
      end
      SEARCH: begin
        re_n = 1'b0;
        rd   = {1'b1, key_q};
        if (cam.cam_match) begin
          hit_d   = 1'b1;
          addr_d  = cam.cam_raddr;
          err_d   = err_q | cam.cam_multi;
          state_d = DONE;
        end else if (count_q == FULL_CNT) begin
          full_d  = 1'b1;
          addr_d  = '0;
          state_d = DONE;
        end else begin
          addr_d  = free_addr;
          state_d = WRITE;
        end
      end
      WRITE: begin
        we_n  = 1'b0;
        waddr = addr_q;
        wd    = {1'b1, key_q};
        if (!valid_q[addr_q]) begin
          valid_d[addr_q] = 1'b1;
          count_d         = count_q + ONE;
        end
        state_d = DONE;
      end
      DEL: begin
        we_n  = 1'b0;
        waddr = del_addr_q;
        if (valid_q[del_addr_q]) begin
          valid_d[del_addr_q] = 1'b0;
          count_d             = count_q - ONE;
        end
        state_d = IDLE;
      end
      DONE: begin
        ins_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req.ins_ready = ins_ready;
  assign req.ins_done  = ins_done;
  assign req.ins_hit   = hit_q;
  assign req.ins_full  = full_q;
  assign req.ins_addr  = addr_q;
  assign req.del_done  = del_done_q;
  assign req.count     = count_q;
  assign req.err       = err_q;

  assign cam.cam_we_   = we_n;
  assign cam.cam_wm    = '0;
  assign cam.cam_wd    = wd;
  assign cam.cam_waddr = waddr;
  assign cam.cam_re_   = re_n;
  assign cam.cam_rm    = '0;
  assign cam.cam_rd    = rd;
endmodule

// File: tb/tb_cam_alloc_ctrl.sv
// Directed bench with a behavioural CAM; expected done responses are queued by stimulus and checked by a monitor.
module tb_cam_alloc_ctrl;
  localparam int KEY   = 16;
  localparam int DEPTH = 32;
  localparam int ADDR  = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cam_alloc_ctrl_if #(.KEY(KEY), .DEPTH(DEPTH)) req ();
  cam_port_if       #(.KEY(KEY), .DEPTH(DEPTH)) cam ();

  cam_alloc_ctrl #(.KEY(KEY), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .cam   (cam)
  );

  typedef struct {
    bit is_del;
    bit hit;
    bit full;
    int addr;
    int cnt;
    int t0;
    int lat;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  exp_t new_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   we_cnt = 0;
  bit   overlap_seen = 0;
  bit   force_multi = 0;
  int   cam_nm;

  logic [KEY:0] cam_mem [DEPTH] = '{default: '0};

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural CAM: synchronous write, combinational search, lowest matching address reported.
  always @(posedge clk) begin
    if (!cam.cam_we_) begin
      cam_mem[cam.cam_waddr] <= cam.cam_wd;
      we_cnt <= we_cnt + 1;
    end
  end

  always_comb begin
    cam_nm        = 0;
    cam.cam_raddr = '0;
    if (!cam.cam_re_) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (cam_mem[i] == cam.cam_rd) begin
          cam_nm        = cam_nm + 1;
          cam.cam_raddr = ADDR'(i);
        end
      end
    end
    cam.cam_match = (cam_nm != 0);
    cam.cam_multi = (cam_nm > 1) || (force_multi && !cam.cam_re_);
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors = vectors + 1;
    if (act != exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!cam.cam_we_ && !cam.cam_re_) overlap_seen = 1;
    if (req.ins_done || req.del_done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        chk("done_kind", int'(req.del_done), int'(mon_e.is_del));
        if (!mon_e.is_del) begin
          chk("ins_hit", int'(req.ins_hit), int'(mon_e.hit));
          chk("ins_full", int'(req.ins_full), int'(mon_e.full));
          chk("ins_addr", int'(req.ins_addr), mon_e.addr);
        end
        chk("count", int'(req.count), mon_e.cnt);
        chk("latency", cyc - mon_e.t0, mon_e.lat);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!req.ins_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", sbq.size(), 0);
  endtask

  task automatic do_ins(input int key, input bit hit, input bit full,
                        input int addr, input int cnt, input int lat);
    wait_ready();
    req.ins_key  = KEY'(key);
    req.ins_req_ = 1'b0;
    new_e = '{0, hit, full, addr, cnt, cyc, lat};
    sbq.push_back(new_e);
    @(negedge clk);
    req.ins_req_ = 1'b1;
  endtask

  task automatic do_del(input int addr, input int cnt);
    wait_ready();
    req.del_addr = ADDR'(addr);
    req.del_req_ = 1'b0;
    new_e = '{1, 0, 0, 0, cnt, cyc, 2};
    sbq.push_back(new_e);
    @(negedge clk);
    req.del_req_ = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation stuck expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int we_before;
    int n;
    bit done_seen;
    req.ins_req_ = 1'b1;
    req.ins_key  = '0;
    req.del_req_ = 1'b1;
    req.del_addr = '0;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ins_ready", int'(req.ins_ready), 1);
    chk("rst_count", int'(req.count), 0);
    chk("rst_err", int'(req.err), 0);
    chk("rst_ins_done", int'(req.ins_done), 0);
    chk("rst_del_done", int'(req.del_done), 0);
    chk("rst_ins_hit", int'(req.ins_hit), 0);
    chk("rst_ins_full", int'(req.ins_full), 0);
    chk("rst_ins_addr", int'(req.ins_addr), 0);
    chk("rst_cam_we_", int'(cam.cam_we_), 1);
    chk("rst_cam_re_", int'(cam.cam_re_), 1);
    chk("rst_cam_wd", int'(cam.cam_wd), 0);
    chk("rst_cam_rd", int'(cam.cam_rd), 0);
    chk("rst_cam_waddr", int'(cam.cam_waddr), 0);
    chk("rst_cam_masks", int'(cam.cam_wm | cam.cam_rm), 0);

    do_ins('h100, 0, 0, 0, 1, 3);
    do_ins('h200, 0, 0, 1, 2, 3);
    do_ins('h400, 0, 0, 2, 3, 3);
    do_ins('h800, 0, 0, 3, 4, 3);
    drain();

    we_before = we_cnt;
    do_ins('h200, 1, 0, 1, 4, 2);
    do_ins('h800, 1, 0, 3, 4, 2);
    drain();
    chk("hit_no_write", we_cnt, we_before);

    do_del(1, 3);
    do_ins('h1000, 0, 0, 1, 4, 3);
    do_ins('h200, 0, 0, 4, 5, 3);
    do_del(20, 5);

    for (int i = 0; i < 27; i++) do_ins('h3000 + i, 0, 0, 5 + i, 6 + i, 3);
    do_ins('h7777, 0, 1, 0, 32, 2);
    drain();

    // Delete and insert presented together: delete is taken first, insert reuses the freed slot.
    wait_ready();
    req.del_addr = ADDR'(7);
    req.del_req_ = 1'b0;
    req.ins_key  = KEY'('hABCD);
    req.ins_req_ = 1'b0;
    new_e = '{1, 0, 0, 0, 31, cyc, 2};
    sbq.push_back(new_e);
    new_e = '{0, 0, 0, 7, 32, cyc, 5};
    sbq.push_back(new_e);
    #1;
    chk("ready_with_del", int'(req.ins_ready), 0);
    @(negedge clk);
    req.del_req_ = 1'b1;
    @(negedge clk);
    @(negedge clk);
    req.ins_req_ = 1'b1;
    drain();

    force_multi = 1;
    do_ins('h100, 1, 0, 0, 32, 2);
    drain();
    force_multi = 0;
    chk("err_set", int'(req.err), 1);
    do_ins('h400, 1, 0, 2, 32, 2);
    drain();
    chk("err_sticky", int'(req.err), 1);

    do_del(9, 31);
    drain();
    wait_ready();
    req.ins_key  = KEY'('h5555);
    req.ins_req_ = 1'b0;
    @(negedge clk);
    req.ins_req_ = 1'b1;
    n = 0;
    while (cam.cam_we_ && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("reached_write", int'(cam.cam_we_), 0);
    reset = 1'b0;
    #1;
    chk("midrst_count", int'(req.count), 0);
    chk("midrst_cam_we_", int'(cam.cam_we_), 1);
    @(negedge clk);
    reset = 1'b1;
    done_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (req.ins_done) done_seen = 1;
    end
    chk("midrst_no_done", int'(done_seen), 0);
    chk("midrst_ready", int'(req.ins_ready), 1);
    chk("midrst_err", int'(req.err), 0);

    chk("we_re_overlap", int'(overlap_seen), 0);
    chk("sb_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
